// File: rtl/spi_master.sv
// Single-byte SPI mode-0 initiator (MSB first) with optional chip-select hold
// so several bytes can be chained inside one frame.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold,
  input  logic       stop,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int            CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_CS_HOLD, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    edge_q, edge_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          tick;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        // start outranks stop when both arrive in WAIT
        if (start) begin
          tx_d    = tx_data;
          hold_d  = hold;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[7];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SETUP;
        end else if (stop && (state_q == S_WAIT)) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_CS_HOLD;
        end
      end
      S_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          edge_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d  = '0;
          edge_d = edge_q + 4'd1;
          // edge_q holds the index of the last edge made; even means it was a rise
          if (edge_q[0]) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (edge_q == 4'd14) begin
              rx_data_d = rx_sh_q;
              done_d    = 1'b1;
              if (hold_q) begin
                busy_d  = 1'b0;
                state_d = S_WAIT;
              end else begin
                state_d = S_CS_HOLD;
              end
            end else begin
              mosi_d = tx_q[3'd6 - edge_q[3:1]];
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CS_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Shift data needs no reset: it is always fully overwritten before use
  always_ff @(posedge clk) begin
    tx_q    <= tx_d;
    rx_sh_q <= rx_sh_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) driving the `spi_bridge` responder from the system clock domain. It generates `cs_n`, `sclk` and `mosi`, and samples `miso`. It can chain bytes under one chip-select assertion. It sits between the host/test sequencer and the SPI pins of the PWM-generator register interface.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles, D ≥ 1. The internal counter is `$clog2(CLK_DIV+1)` bits.
- `clk` in 1: system clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a byte transfer; accepted only in IDLE or WAIT.
- `tx_data` in 8: byte to send; latched on accept.
- `hold` in 1: latched on accept; 1 keeps `cs_n` low after the byte (go to WAIT).
- `stop` in 1: in WAIT, ends the frame.
- `busy` out 1: high from accept until entry to IDLE or WAIT.
- `done` out 1: one-cycle pulse when the byte completes.
- `rx_data` out 8: last received byte; updated together with `done`.
- `sclk` out 1: SPI clock; idles low.
- `cs_n` out 1: chip select, active low.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation
- **Reset values:** `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0. FSM goes to IDLE.
- **IDLE.** `cs_n`=1, `mosi`=0.
  - On `start`: latch `tx_data` and `hold`, set `cs_n`=0, `mosi`=`tx_data[7]`, `busy`=1, go to SETUP.
- **SETUP.** Wait D cycles, then drive `sclk` high and go to SHIFT.
- **SHIFT.** `sclk` toggles every D cycles; an edge counter runs 0..15.
  - On a rising edge (rise k, k=0..7): `rx_sh <= {rx_sh[6:0], miso}`. Sample the `miso` value present before the edge; the responder shifts on that same edge.
  - On a falling edge k, k=0..6: `mosi <= tx[6-k]`.
  - On the 8th falling edge: `rx_data <= rx_sh` and pulse `done`. `mosi` holds `tx[0]`.
  - Then: if `hold`=1, go to WAIT; otherwise go to CS_HOLD.
- **WAIT.** `cs_n`=0, `sclk`=0, `busy`=0.
  - `start` → latch new byte and `hold`, `mosi`=`tx[7]`, go to SETUP.
  - `stop` → go to CS_HOLD.
  - `start` and `stop` in the same cycle: `start` wins and `stop` is dropped.
- **CS_HOLD.** Wait D cycles, then set `cs_n`=1, `mosi`=0, go to GAP.
- **GAP.** Wait D cycles; this is the minimum `cs_n`-high time so the responder reloads its transmit byte. Then `busy`=0 and go to IDLE.
- **Ignored inputs:**
  - `start` in SETUP, SHIFT, CS_HOLD or GAP is dropped; `tx_data` is not re-sampled.
  - `stop` outside WAIT is dropped.
- **Reset mid-transfer:** all outputs return to their reset values immediately. A partial byte is discarded and `rx_data` is cleared. The responder sees `cs_n` high and resynchronises.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Timing
Let E0 be the `clk` edge at which `start` is accepted.
- `cs_n` falls and `busy` rises after E0. `mosi`=`tx[7]` from E0.
- `sclk` rising edges at E0+D+2kD and falling edges at E0+2D+2kD, for k=0..7.
- `done` and `rx_data` update at E0+16D. `done` is high for exactly one cycle.
- With `hold`=0:
  - `cs_n` rises at E0+17D.
  - `busy` falls at E0+18D.
  - The next `start` can be accepted at E0+18D, giving a frame period of 18D.
- With `hold`=1:
  - WAIT is entered at E0+16D, with `busy` low from that edge.
  - A `start` accepted at edge E1 has its first `sclk` rise at E1+D.
- `stop` accepted at Es: `cs_n` rises at Es+D and `busy` falls at Es+2D.
- For D=1: `sclk` period is 2 `clk` cycles, `done` at E0+16, `cs_n` high at E0+17.

## Test plan
- **Basic byte.** D=4, `tx_data`=0xA5, `hold`=0, responder `data_out`=0x3C.
  - `sclk` rises at cycles 4, 12, …, 60.
  - `done` at cycle 64 with `rx_data`=0x3C; responder `data_in`=0xA5.
  - `cs_n` high at cycle 68, `busy` low at cycle 72.
- **Chained bytes.** Send 0x12 with `hold`=1, then 0x34 with `hold`=0.
  - `cs_n` stays low across both bytes.
  - Two `done` pulses and two responder `byte_sync` events.
  - Responder receives 0x12 then 0x34.
- **Start while busy.** Assert `start` with `tx_data`=0xFF at cycle 20 of an 0xA5 transfer.
  - No effect; responder receives only 0xA5.
  - `busy` and `cs_n` timing are identical to the basic-byte test.
- **Reset mid-transfer.** Assert `rst` after the 3rd `sclk` rise.
  - Same cycle: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `rx_data`=0.
  - A following 0x5A transfer completes with the responder `data_in`=0x5A.
- **Fast divider loopback.** D=1, `miso` tied to `mosi` through a one-bit register that updates on `sclk` rise; send 0xC3, then 0x00.
  - `done` at E0+16.
  - `rx_data` matches the expected shifted pattern.
- **WAIT contention.** In WAIT, assert `start` (0x77, `hold`=0) and `stop` in the same cycle.
  - The byte is sent with `cs_n` never rising before it.
  - `cs_n` rises D cycles after the byte's `done`.
